// File: rtl/reflet_vga_fill_engine.sv
// Memory-mapped rectangle-fill sequencer for the 160x120 6-bit-color VGA framebuffer.
// Optional completion interrupt and CTRL.bit7 mask are built when REFLET_VGA_FILL_IRQ_EN is defined.
module reflet_vga_fill_engine #(
  parameter int                        base_addr_size = 16,
  parameter logic [base_addr_size-1:0] base_addr      = 16'hFF28,
  parameter int                        h_res          = 160,
  parameter int                        v_res          = 120
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [base_addr_size-1:0] addr,
  input  logic [7:0]                data_in,
  output logic [7:0]                data_out,
  input  logic                      write_en,
  output logic                      px_we,
  output logic [7:0]                px_h,
  output logic [6:0]                px_v,
  output logic [5:0]                px_color
`ifdef REFLET_VGA_FILL_IRQ_EN
  ,
  output logic                      irq
`endif
);

  typedef enum logic {IDLE, FILL} state_t;

  localparam logic [base_addr_size:0] addr_lo = {1'b0, base_addr};
  localparam logic [base_addr_size:0] addr_hi = addr_lo + (base_addr_size+1)'(5);

  state_t      state_reg, state_next;
  logic [7:0]  x0_reg, y0_reg, w_reg, h_reg;
  logic [5:0]  color_reg, color_sh_reg;
  logic        done_reg, done_next;
  // Counters and end points are 9 bits so X0+W-1 / Y0+H-1 never wrap.
  logic [8:0]  cx_reg, cy_reg, x_start_reg, x_end_reg, y_end_reg;
  logic        load, advance;
  logic        sel, wr, ctrl_wr, start_req, abort_req, clr_req;
  logic        zero_size, last_px, clip_ok, mask_bit;
  logic [2:0]  reg_idx;
  logic [base_addr_size:0] addr_ext;

  assign addr_ext  = {1'b0, addr};
  assign sel       = enable && (addr_ext >= addr_lo) && (addr_ext <= addr_hi);
  // Offsets only span 0..5, so the low three bits of the difference suffice.
  assign reg_idx   = addr[2:0] - base_addr[2:0];
  assign wr        = sel && write_en;
  assign ctrl_wr   = wr && (reg_idx == 3'd5);
  assign abort_req = ctrl_wr && data_in[1];
  assign start_req = ctrl_wr && data_in[0] && !data_in[1];
  assign clr_req   = ctrl_wr && data_in[2];
  assign zero_size = (w_reg == 8'd0) || (h_reg == 8'd0);
  assign last_px   = (cx_reg == x_end_reg) && (cy_reg == y_end_reg);
  assign clip_ok   = (cx_reg < 9'(h_res)) && (cy_reg < 9'(v_res));

  always_comb begin
    state_next = state_reg;
    done_next  = done_reg;
    load       = 1'b0;
    advance    = 1'b0;
    if (clr_req)
      done_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start_req) begin
          done_next = zero_size;
          if (!zero_size) begin
            state_next = FILL;
            load       = 1'b1;
          end
        end
      end
      FILL: begin
        if (abort_req) begin
          state_next = IDLE;
        end else begin
          advance = 1'b1;
          if (last_px) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      done_reg     <= 1'b0;
      x0_reg       <= '0;
      y0_reg       <= '0;
      w_reg        <= '0;
      h_reg        <= '0;
      color_reg    <= '0;
      color_sh_reg <= '0;
      cx_reg       <= '0;
      cy_reg       <= '0;
      x_start_reg  <= '0;
      x_end_reg    <= '0;
      y_end_reg    <= '0;
      px_we        <= 1'b0;
      px_h         <= '0;
      px_v         <= '0;
      px_color     <= '0;
    end else begin
      state_reg <= state_next;
      done_reg  <= done_next;
      if (wr) begin
        case (reg_idx)
          3'd0:    x0_reg    <= data_in;
          3'd1:    y0_reg    <= data_in;
          3'd2:    w_reg     <= data_in;
          3'd3:    h_reg     <= data_in;
          3'd4:    color_reg <= data_in[5:0];
          default: ;
        endcase
      end
      if (load) begin
        cx_reg       <= {1'b0, x0_reg};
        cy_reg       <= {1'b0, y0_reg};
        x_start_reg  <= {1'b0, x0_reg};
        x_end_reg    <= {1'b0, x0_reg} + {1'b0, w_reg} - 9'd1;
        y_end_reg    <= {1'b0, y0_reg} + {1'b0, h_reg} - 9'd1;
        color_sh_reg <= color_reg;
      end else if (advance) begin
        if (cx_reg == x_end_reg) begin
          cx_reg <= x_start_reg;
          cy_reg <= cy_reg + 9'd1;
        end else begin
          cx_reg <= cx_reg + 9'd1;
        end
      end
      // Clipped positions still consume their cycle, just without a write.
      if (advance) begin
        px_we    <= clip_ok;
        px_h     <= cx_reg[7:0];
        px_v     <= cy_reg[6:0];
        px_color <= color_sh_reg;
      end else begin
        px_we <= 1'b0;
      end
    end
  end

`ifdef REFLET_VGA_FILL_IRQ_EN
  logic mask_reg, mask_next;
  assign mask_next = ctrl_wr ? data_in[7] : mask_reg;
  assign mask_bit  = mask_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mask_reg <= 1'b0;
      irq      <= 1'b0;
    end else begin
      mask_reg <= mask_next;
      irq      <= done_next && !mask_next;
    end
  end
`else
  assign mask_bit = 1'b0;
`endif

  always_comb begin
    data_out = 8'h00;
    if (sel) begin
      case (reg_idx)
        3'd0:    data_out = x0_reg;
        3'd1:    data_out = y0_reg;
        3'd2:    data_out = w_reg;
        3'd3:    data_out = h_reg;
        3'd4:    data_out = {2'b00, color_reg};
        3'd5:    data_out = {mask_bit, 5'b00000, done_reg, state_reg == FILL};
        default: data_out = 8'h00;
      endcase
    end
  end

endmodule
